// File: rtl/stereo_pattern_gen_if.sv
// Stereo video bus between the pattern generator and the stereo matcher.
//   enable      : run request into the generator (level)
//   de_out      : active-pixel data enable
//   h_sync_out  : horizontal sync (polarity set by the generator)
//   v_sync_out  : vertical sync
//   pixel_left  : left image pixel, 0 outside active video
//   pixel_right : right image pixel, 0 outside active video
//   busy        : a frame is being emitted
//   frame_cnt   : completed-frame counter (STEREO_PATTERN_GEN_SCROLL_EN builds only)
// master = generator side, slave = consumer side.
interface stereo_pattern_gen_if;
  logic       enable;
  logic       de_out;
  logic       h_sync_out;
  logic       v_sync_out;
  logic [7:0] pixel_left;
  logic [7:0] pixel_right;
  logic       busy;
`ifdef STEREO_PATTERN_GEN_SCROLL_EN
  logic [7:0] frame_cnt;
`endif

  modport master (
    input  enable,
    output de_out, h_sync_out, v_sync_out, pixel_left, pixel_right, busy
`ifdef STEREO_PATTERN_GEN_SCROLL_EN
    , output frame_cnt
`endif
  );

  modport slave (
    output enable,
    input  de_out, h_sync_out, v_sync_out, pixel_left, pixel_right, busy
`ifdef STEREO_PATTERN_GEN_SCROLL_EN
    , input frame_cnt
`endif
  );
endinterface

// File: rtl/stereo_pattern_gen.sv
// Synthetic stereo video source standing in for camera capture in front of
// the stereo matcher. Raster timing comes from h/v counters; left and right
// pixels come from one texture, the right image shifted by DISP pixels so the
// matcher's expected disparity is known.
//
// Ports:
//   clk     : pixel clock
//   rst_n   : synchronous active-low reset
//   clk_out : clk pass-through
//   vid     : stereo_pattern_gen_if.master (enable in; de/syncs/pixels/busy out)
//
// Optional feature macro STEREO_PATTERN_GEN_SCROLL_EN: adds vid.frame_cnt and
// adds frame_cnt to the texture y term so the pattern scrolls each frame.
//
// Pipeline: state -> counter stage (r_h_cnt/r_v_cnt, qualified by r_cnt_vld)
// -> registered output stage. The first RUN cycle only arms the counter stage,
// so enable seen at edge N gives counters (0,0) after N+1 and de after N+2.
module stereo_pattern_gen #(
  parameter int H_ACTIVE         = 64,
  parameter int H_FRONT          = 4,
  parameter int H_SYNC           = 8,
  parameter int H_BACK           = 4,
  parameter int V_ACTIVE         = 64,
  parameter int V_FRONT          = 2,
  parameter int V_SYNC           = 2,
  parameter int V_BACK           = 2,
  parameter int SYNC_ACTIVE_HIGH = 1,
  parameter int DISP             = 3,
  parameter int PATTERN_MUL      = 37
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  clk_out,
  stereo_pattern_gen_if.master  vid
);
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_W = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT_W = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic          SYNC_ON  = (SYNC_ACTIVE_HIGH != 0);
  localparam logic          SYNC_OFF = ~SYNC_ON;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t        r_state, w_state_nxt;
  logic [HW-1:0] r_h_cnt, w_h_nxt;
  logic [VW-1:0] r_v_cnt, w_v_nxt;
  logic          r_cnt_vld;
  logic          w_line_end, w_frame_end;

  logic          r_de, r_hs, r_vs, r_busy;
  logic [7:0]    r_pix_l, r_pix_r;
  logic          w_de, w_hs_on, w_vs_on;
  logic [31:0]   w_y;
  logic [7:0]    w_tex_l, w_tex_r;

  assign clk_out     = clk;
  assign w_line_end  = (r_h_cnt == H_LAST);
  assign w_frame_end = w_line_end && (r_v_cnt == V_LAST);

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (vid.enable) w_state_nxt = S_RUN;
      S_RUN:   if (!vid.enable) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        // Re-enable wins even on the last cycle: the next frame follows seamlessly.
        if (vid.enable)                    w_state_nxt = S_RUN;
        else if (r_cnt_vld && w_frame_end) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- counter stage ----------------
  always_comb begin
    w_h_nxt = r_h_cnt;
    w_v_nxt = r_v_cnt;
    if (w_state_nxt == S_IDLE) begin
      w_h_nxt = '0;
      w_v_nxt = '0;
    end else if (r_cnt_vld) begin
      if (w_line_end) begin
        w_h_nxt = '0;
        w_v_nxt = (r_v_cnt == V_LAST) ? '0 : r_v_cnt + VW'(1);
      end else begin
        w_h_nxt = r_h_cnt + HW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_h_cnt   <= '0;
      r_v_cnt   <= '0;
      r_cnt_vld <= 1'b0;
    end else begin
      r_h_cnt   <= w_h_nxt;
      r_v_cnt   <= w_v_nxt;
      // Valid from the second RUN cycle on; drops together with the counter
      // clear on the drain-to-idle edge.
      r_cnt_vld <= (r_state != S_IDLE) && (w_state_nxt != S_IDLE);
    end
  end

  // ---------------- texture ----------------
`ifdef STEREO_PATTERN_GEN_SCROLL_EN
  logic [7:0] r_fc_c;      // frame index seen by the counter stage
  logic [7:0] r_frame_cnt; // same index, aligned with the output stage

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fc_c      <= '0;
      r_frame_cnt <= '0;
    end else begin
      if (r_cnt_vld && w_frame_end) r_fc_c <= r_fc_c + 8'd1;
      r_frame_cnt <= r_fc_c;
    end
  end

  assign vid.frame_cnt = r_frame_cnt;
  assign w_y = 32'(r_v_cnt) + 32'(r_fc_c);
`else
  assign w_y = 32'(r_v_cnt);
`endif

  // Full 32-bit products, truncated to 8 bits only at the end.
  assign w_tex_l = 8'(32'(r_h_cnt) * 32'(PATTERN_MUL) + w_y);
  assign w_tex_r = 8'((32'(r_h_cnt) + 32'(DISP)) * 32'(PATTERN_MUL) + w_y);

  // ---------------- output stage ----------------
  assign w_de    = r_cnt_vld && (r_h_cnt < H_ACT_W) && (r_v_cnt < V_ACT_W);
  assign w_hs_on = r_cnt_vld && (r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END);
  assign w_vs_on = r_cnt_vld && (r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_de    <= 1'b0;
      r_hs    <= SYNC_OFF;
      r_vs    <= SYNC_OFF;
      r_pix_l <= '0;
      r_pix_r <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_de    <= w_de;
      r_hs    <= w_hs_on ? SYNC_ON : SYNC_OFF;
      r_vs    <= w_vs_on ? SYNC_ON : SYNC_OFF;
      r_pix_l <= w_de ? w_tex_l : 8'h00;
      r_pix_r <= w_de ? w_tex_r : 8'h00;
      // Running flag delayed to line up with the output stage.
      r_busy  <= r_cnt_vld;
    end
  end

  assign vid.de_out      = r_de;
  assign vid.h_sync_out  = r_hs;
  assign vid.v_sync_out  = r_vs;
  assign vid.pixel_left  = r_pix_l;
  assign vid.pixel_right = r_pix_r;
  assign vid.busy        = r_busy;
endmodule

// File: tb/tb_stereo_pattern_gen.sv
module tb_stereo_pattern_gen;
  localparam int HA = 64, HF = 4, HS = 8, HB = 4;
  localparam int VA = 64, VF = 2, VS = 2, VB = 2;
  localparam int SAH = 1, DISP = 3, PM = 37;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam logic SON  = (SAH != 0);
  localparam logic SOFF = ~SON;
`ifdef STEREO_PATTERN_GEN_SCROLL_EN
  localparam int SCR = 1;
`else
  localparam int SCR = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic clk_out;

  stereo_pattern_gen_if vid();

  stereo_pattern_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_ACTIVE_HIGH(SAH), .DISP(DISP), .PATTERN_MUL(PM)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clk_out (clk_out),
    .vid     (vid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic [7:0] pl;
    logic [7:0] pr;
    logic [7:0] fc;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic       mon_en = 1'b0;
  int         run;
  logic [7:0] rq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: output of frame f, raster index k, straight from the raster rules.
  function automatic exp_t model(input int f, input int k);
    exp_t e;
    int x = k % HT;
    int y = k / HT;
    int yt = y + ((SCR != 0) ? f : 0);
    e.de = (x < HA) && (y < VA);
    e.hs = (x >= HA + HF && x < HA + HF + HS) ? SON : SOFF;
    e.vs = (y >= VA + VF && y < VA + VF + VS) ? SON : SOFF;
    e.pl = e.de ? 8'((x * PM + yt) % 256) : 8'h00;
    e.pr = e.de ? 8'(((x + DISP) * PM + yt) % 256) : 8'h00;
    e.fc = (SCR != 0) ? 8'(f % 256) : 8'h00;
    return e;
  endfunction

  task automatic push_frames(input int f0, input int n);
    for (int f = f0; f < f0 + n; f++)
      for (int k = 0; k < FRAME; k++) sb.push_back(model(f, k));
  endtask

  // Monitor: pops one expectation per busy cycle; idle cycles must be quiet.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t a, e;
      a.de = vid.de_out;
      a.hs = vid.h_sync_out;
      a.vs = vid.v_sync_out;
      a.pl = vid.pixel_left;
      a.pr = vid.pixel_right;
`ifdef STEREO_PATTERN_GEN_SCROLL_EN
      a.fc = vid.frame_cnt;
`else
      a.fc = 8'h00;
`endif
      if (vid.busy) begin
        if (sb.size() == 0) chk("unexpected_busy", 64'd1, 64'd0);
        else begin
          e = sb.pop_front();
          chk("stream", 64'(a), 64'(e));
        end
      end else begin
        chk("idle_quiet", {a.de, a.hs, a.vs, a.pl, a.pr},
            {1'b0, SOFF, SOFF, 8'h00, 8'h00});
      end
      // right(x-DISP) must equal left(x) along each active run
      if (vid.de_out) begin
        if (run >= DISP) chk("disparity", 64'(rq[run - DISP]), 64'(vid.pixel_left));
        rq.push_back(vid.pixel_right);
        run++;
      end else begin
        run = 0;
        rq.delete();
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((vid.busy || sb.size() != 0) && n < 3 * FRAME) begin
      step();
      n++;
    end
    chk(tag, 64'((vid.busy || sb.size() != 0) ? 1 : 0), 64'd0);
    repeat (20) step();
  endtask

  initial begin
    int d1, r;
    run = 0;
    rst_n = 1'b0;
    vid.enable = 1'b0;
    repeat (3) step();
    chk("reset_state", {vid.de_out, vid.busy, vid.h_sync_out, vid.v_sync_out,
                        vid.pixel_left, vid.pixel_right},
        {1'b0, 1'b0, SOFF, SOFF, 8'h00, 8'h00});
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (5) step();

    // Burst 1: two frames, enable dropped mid frame 1; check start latency.
    push_frames(0, 2);
    vid.enable = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    chk("busy_before_first", 64'(vid.busy), 64'd0);
    @(posedge clk); #1;
    chk("first_de", {vid.busy, vid.de_out}, 2'b11);
    chk("first_left", 64'(vid.pixel_left), 64'd0);
    chk("first_right", 64'(vid.pixel_right), 64'd111);
    repeat (FRAME + $urandom_range(200, FRAME - 200)) step();
    vid.enable = 1'b0;
    wait_idle("burst1_drain");

    // Burst 2: drop enable in frame 0, re-raise during drain, drop in frame 1.
    push_frames(2, 2);
    vid.enable = 1'b1;
    d1 = $urandom_range(500, FRAME - 500);
    repeat (d1) step();
    vid.enable = 1'b0;
    r = $urandom_range(5, 100);
    repeat (r) step();
    vid.enable = 1'b1;
    repeat (FRAME + 1000 - d1 - r) step();
    vid.enable = 1'b0;
    wait_idle("burst2_drain");

    // Burst 3: one-cycle reset at output pixel (30,30), then restart.
    push_frames(4, 1);
    vid.enable = 1'b1;
    repeat (3 + 30 * HT + 30) step();
    rst_n = 1'b0;
    sb.delete();
    push_frames(0, 1);
    step();
    chk("after_reset", {vid.de_out, vid.busy, vid.h_sync_out, vid.v_sync_out},
        {1'b0, 1'b0, SOFF, SOFF});
    rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    chk("restart_busy_early", 64'(vid.busy), 64'd0);
    @(posedge clk); #1;
    chk("restart_first", {vid.busy, vid.de_out, vid.pixel_left, vid.pixel_right},
        {1'b1, 1'b1, 8'd0, 8'd111});
    repeat (100) step();
    vid.enable = 1'b0;
    wait_idle("burst3_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
